// File: rtl/binary_mul_12_1_bi.sv
// binary_mul_12_1_bi: fully pipelined 12x12 signed multiplier.
// Input register, eleven shift-add stages and an output register give
// thirteen register stages in total. The last partial product (B[11]) is
// subtracted so that the two's-complement multiplier weight -2^11 is
// honoured. Sums are kept modulo 2^23, which is exactly the width of P.
module binary_mul_12_1_bi (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] A,
  input  logic [11:0] B,
  output logic [22:0] P
);

  // Sign-extended multiplicand shifted to weight 2^sh when the multiplier bit is set.
  function automatic logic [22:0] pp(input logic [11:0] a, input logic bit_i,
                                     input int unsigned sh);
    logic [22:0] ext;
    ext = {{11{a[11]}}, a};
    return bit_i ? (ext << sh) : '0;
  endfunction

  logic [11:0] a0_q, b0_q;
  logic [22:0] s11_d, s11_q;
  logic [22:0] p_q;

  // Input register stage: capture operands.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a0_q <= '0;
      b0_q <= '0;
    end else if (en) begin
      a0_q <= A;
      b0_q <= B;
    end
  end

  // Stage k holds the partial sum of products 0..k and the multiplier bits
  // B[11:k+1] still to be consumed, so each stage's B register shrinks by one bit.
  for (genvar k = 1; k <= 10; k++) begin : g_stg
    logic [22:0]   s_d, s_q;
    logic [11:0]   a_d, a_q;
    logic [10-k:0] b_d, b_q;

    if (k == 1) begin : g_first
      // First adding stage folds in partial products 0 and 1.
      always_comb begin
        s_d = pp(a0_q, b0_q[0], 0) + pp(a0_q, b0_q[1], 1);
        a_d = a0_q;
        b_d = b0_q[11:2];
      end
    end else begin : g_mid
      // Add partial product k; the lowest carried multiplier bit is B[k].
      always_comb begin
        s_d = g_stg[k-1].s_q + pp(g_stg[k-1].a_q, g_stg[k-1].b_q[0], k);
        a_d = g_stg[k-1].a_q;
        b_d = g_stg[k-1].b_q[11-k:1];
      end
    end

    // Stage register with synchronous reset taking priority over enable.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        s_q <= '0;
        a_q <= '0;
        b_q <= '0;
      end else if (en) begin
        s_q <= s_d;
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  // Final adding stage: the sign-bit partial product is subtracted.
  always_comb begin
    s11_d = g_stg[10].s_q - pp(g_stg[10].a_q, g_stg[10].b_q[0], 11);
  end

  // Last adding stage register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s11_q <= '0;
    end else if (en) begin
      s11_q <= s11_d;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      p_q <= '0;
    end else if (en) begin
      p_q <= s11_q;
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_binary_mul_12_1_bi.sv
// Testbench for binary_mul_12_1_bi: directed scenarios plus randomized
// traffic, checked against a queue-based model of "the product accepted
// 12 enabled edges ago since the last reset".
module tb_binary_mul_12_1_bi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [11:0] A = '0;
  logic [11:0] B = '0;
  logic [22:0] P;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          seen_rst = 1'b0;
  logic [22:0] hist[$];

  binary_mul_12_1_bi dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .A    (A),
    .B    (B),
    .P    (P)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] prod(input logic [11:0] a, input logic [11:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[22:0];
  endfunction

  function automatic logic [22:0] model_p();
    return (hist.size() == 13) ? hist[0] : 23'd0;
  endfunction

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: P=%0d (0x%h) expected %0d (0x%h)", tag,
               $signed(got), got, $signed(exp), exp);
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check P just after it.
  task automatic step(input logic [11:0] a, input logic [11:0] b,
                      input logic e, input logic r, input string tag);
    A = a; B = b; en = e; rst_n = r;
    @(posedge clk);
    if (r) begin
      hist.delete();
      seen_rst = 1'b1;
    end else if (e) begin
      hist.push_back(prod(a, b));
      if (hist.size() > 13) void'(hist.pop_front());
    end
    #1;
    if (seen_rst) chk(tag, P, model_p());
  endtask

  task automatic hold(input int sa, input int sb, input logic [22:0] exp, input string tag);
    for (int i = 0; i < 13; i++) step(12'(sa), 12'(sb), 1'b1, 1'b0, tag);
    chk({tag, "_const"}, P, exp);
  endtask

  initial begin
    // Reset with A=5, B=7 present; P stays 0 for 12 edges after deassert.
    step(12'd5, 12'd7, 1'b1, 1'b1, "rst");
    step(12'd5, 12'd7, 1'b1, 1'b1, "rst");
    chk("rst_zero", P, 23'd0);
    for (int i = 0; i < 12; i++) step(12'd5, 12'd7, 1'b1, 1'b0, "post_rst");
    chk("post_rst_still0", P, 23'd0);
    step(12'd5, 12'd7, 1'b1, 1'b0, "first");
    chk("first_35", P, 23'd35);

    // Spot values and the single wrapping case.
    hold(2047, 2047, 23'd4190209, "max_max");
    hold(-2048, 2047, 23'(-4192256), "min_max");
    hold(-1, -1, 23'd1, "m1_m1");
    hold(0, -2048, 23'd0, "zero_min");
    hold(-2048, -2048, 23'h400000, "wrap");

    // Back-to-back stream A=1..20, B=-3.
    for (int i = 1; i <= 20; i++) step(12'(i), 12'(-3), 1'b1, 1'b0, "stream");
    for (int i = 0; i < 14; i++) step(12'd0, 12'd0, 1'b1, 1'b0, "stream_tail");

    // Stall of 4 cycles mid-stream; garbage on A/B during the stall is ignored.
    step(12'd100, 12'd2, 1'b1, 1'b0, "stall");
    step(12'd101, 12'd2, 1'b1, 1'b0, "stall");
    for (int i = 0; i < 4; i++) step(12'(777 + i), 12'd9, 1'b0, 1'b0, "stalled");
    step(12'd102, 12'd2, 1'b1, 1'b0, "stall");
    for (int i = 0; i < 9; i++) step(12'd0, 12'd0, 1'b1, 1'b0, "stall_drain");
    step(12'd0, 12'd0, 1'b1, 1'b0, "stall_out");
    chk("stall_200", P, 23'd200);
    step(12'd0, 12'd0, 1'b0, 1'b0, "stall_hold");
    chk("stall_hold200", P, 23'd200);
    step(12'd0, 12'd0, 1'b1, 1'b0, "stall_out");
    chk("stall_202", P, 23'd202);
    step(12'd0, 12'd0, 1'b1, 1'b0, "stall_out");
    chk("stall_204", P, 23'd204);
    for (int i = 0; i < 12; i++) step(12'd0, 12'd0, 1'b1, 1'b0, "stall_flush");

    // Mid-flight reset discards five operands in flight.
    for (int i = 1; i <= 5; i++) step(12'(i * 11), 12'd13, 1'b1, 1'b0, "inflight");
    step(12'd3, 12'd3, 1'b0, 1'b1, "midrst");
    for (int i = 0; i < 12; i++) begin
      step(12'd3, 12'd4, 1'b1, 1'b0, "after_midrst");
      chk("midrst_zero", P, 23'd0);
    end
    step(12'd3, 12'd4, 1'b1, 1'b0, "after_midrst");
    chk("midrst_new", P, 23'd12);

    // Randomized traffic with random enable and occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(12'($urandom), 12'($urandom), 1'($urandom_range(0, 9) < 8),
           1'($urandom_range(0, 99) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
